// File: rtl/online_softmax_stats.sv
// online_softmax_stats
//   Streaming row statistics for a base-2 softmax. Rows arrive as chunks of
//   NUM signed fixed-point lanes; the block keeps the running row maximum m
//   and the running sum l = sum 2^(x - m). When a chunk raises the maximum,
//   the old sum is rescaled by 2^(m_old - m_new) before the new lanes are added.
//   Chunk flow: IDLE (accept) -> MAX -> RESCALE -> ACC (NUM cycles) -> DONE.
//
// Ports
//   I_CLK, I_RST         clock, asynchronous active-high reset
//   I_VLD / O_RDY        chunk handshake (O_RDY high only in IDLE)
//   I_FIRST, I_LAST      row delimiters, latched with the chunk
//   I_DATA[0:NUM-1]      chunk lanes, signed Q(D_W-FRAC).FRAC
//   O_X_MAX, O_EXP_SUM   registered statistics, updated on entry to DONE
//   O_CHUNK_DONE, O_VLD  one-cycle pulses: chunk folded in / row final

module online_softmax_stats #(
    parameter int D_W   = 16,
    parameter int FRAC  = 8,
    parameter int NUM   = 16,
    parameter int SUM_W = 24
) (
    input  logic                    I_CLK,
    input  logic                    I_RST,
    input  logic                    I_VLD,
    output logic                    O_RDY,
    input  logic                    I_FIRST,
    input  logic                    I_LAST,
    input  logic signed [D_W-1:0]   I_DATA [0:NUM-1],
    output logic signed [D_W-1:0]   O_X_MAX,
    output logic [SUM_W-1:0]        O_EXP_SUM,
    output logic                    O_CHUNK_DONE,
    output logic                    O_VLD
);

    localparam int CW = $clog2(NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAX,
        S_RESCALE,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic signed [D_W-1:0] M_NEG = {1'b1, {(D_W-1){1'b0}}};
    localparam logic [SUM_W-1:0]      L_SAT = '1;
    localparam logic [FRAC:0]         E_ONE = {1'b1, {FRAC{1'b0}}};
    localparam logic [D_W:0]          N_MAX = (D_W+1)'(FRAC);
    localparam logic [CW-1:0]         CNT_LAST = CW'(NUM - 1);

    // Difference in D_W+1 bits so that even max - min cannot overflow.
    function automatic logic signed [D_W:0] sdiff(input logic signed [D_W-1:0] a,
                                                   input logic signed [D_W-1:0] b);
        logic signed [D_W:0] ae;
        logic signed [D_W:0] be;
        ae = {a[D_W-1], a};
        be = {b[D_W-1], b};
        return ae - be;
    endfunction

    // Approximate 2^d for d <= 0: integer part becomes a right shift, the
    // fractional part uses the linear fit 2^-f ~= 1 - f/2.
    function automatic logic [FRAC:0] exp2_neg(input logic signed [D_W:0] d);
        logic [D_W:0]  y;
        logic [D_W:0]  n;
        logic [FRAC:0] f_half;
        logic [FRAC:0] base;
        y      = -d;
        n      = y >> FRAC;
        f_half = {1'b0, y[FRAC-1:0]} >> 1;
        base   = E_ONE - f_half;
        if (n > N_MAX) return '0;
        return base >> n;
    endfunction

    state_t                 state;
    state_t                 state_nx;
    logic signed [D_W-1:0]  data_q [NUM];
    logic                   first_q;
    logic                   last_q;
    logic signed [D_W-1:0]  m_q;
    logic signed [D_W-1:0]  m_prev_q;
    logic [SUM_W-1:0]       l_q;
    logic [CW-1:0]          cnt_q;

    logic signed [D_W-1:0]  lane_max;
    logic signed [D_W-1:0]  m_old;
    logic signed [D_W-1:0]  m_new;
    logic [FRAC:0]          e_res;
    logic [SUM_W+FRAC:0]    prod;
    logic [SUM_W+FRAC:0]    prod_sh;
    logic [SUM_W-1:0]       l_res;
    logic signed [D_W-1:0]  x_cur;
    logic [FRAC:0]          e_acc;
    logic [SUM_W:0]         acc;
    logic [SUM_W-1:0]       l_acc;

    assign O_RDY = (state == S_IDLE);

    // Reduction over the latched lanes, then merged with the running max.
    always_comb begin
        lane_max = data_q[0];
        for (int i = 1; i < NUM; i++) begin
            if (data_q[i] > lane_max) lane_max = data_q[i];
        end
    end

    assign m_old = first_q ? M_NEG : m_q;
    assign m_new = (lane_max > m_old) ? lane_max : m_old;

    // Rescale: m_prev_q/m_q hold old and new maxima after S_MAX. The shifted
    // product never exceeds l_q since E <= 1.0, but clamp anyway.
    assign e_res   = exp2_neg(sdiff(m_prev_q, m_q));
    assign prod    = {{(FRAC+1){1'b0}}, l_q} * {{SUM_W{1'b0}}, e_res};
    assign prod_sh = prod >> FRAC;
    assign l_res   = (|prod_sh[SUM_W+FRAC:SUM_W]) ? L_SAT : prod_sh[SUM_W-1:0];

    // Accumulate one lane per cycle; the carry bit signals saturation.
    assign x_cur = data_q[cnt_q];
    assign e_acc = exp2_neg(sdiff(x_cur, m_q));
    assign acc   = {1'b0, l_q} + {{(SUM_W-FRAC){1'b0}}, e_acc};
    assign l_acc = acc[SUM_W] ? L_SAT : acc[SUM_W-1:0];

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (I_VLD) state_nx = S_MAX;
            S_MAX:     state_nx = S_RESCALE;
            S_RESCALE: state_nx = S_ACC;
            S_ACC:     if (cnt_q == CNT_LAST) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            for (int i = 0; i < NUM; i++) data_q[i] <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            m_q          <= '0;
            m_prev_q     <= '0;
            l_q          <= '0;
            cnt_q        <= '0;
            O_X_MAX      <= '0;
            O_EXP_SUM    <= '0;
            O_CHUNK_DONE <= 1'b0;
            O_VLD        <= 1'b0;
        end else begin
            O_CHUNK_DONE <= 1'b0;
            O_VLD        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_VLD) begin
                        for (int i = 0; i < NUM; i++) data_q[i] <= I_DATA[i];
                        first_q <= I_FIRST;
                        last_q  <= I_LAST;
                    end
                end
                S_MAX: begin
                    m_prev_q <= m_old;
                    m_q      <= m_new;
                end
                S_RESCALE: begin
                    l_q   <= first_q ? '0 : l_res;
                    cnt_q <= '0;
                end
                S_ACC: begin
                    l_q <= l_acc;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q        <= '0;
                        // Outputs publish on entry to S_DONE so the pulses
                        // and the new statistics appear together.
                        O_X_MAX      <= m_q;
                        O_EXP_SUM    <= l_acc;
                        O_CHUNK_DONE <= 1'b1;
                        O_VLD        <= last_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_online_softmax_stats.sv
module tb_online_softmax_stats;

    localparam int D_W   = 16;
    localparam int FRAC  = 8;
    localparam int NUM   = 16;
    localparam int SUM_W = 24;
    localparam longint LSAT = (64'd1 << SUM_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    logic first = 1'b0;
    logic last = 1'b0;
    logic signed [D_W-1:0] data [0:NUM-1];
    logic rdy;
    logic signed [D_W-1:0] xmax;
    logic [SUM_W-1:0] esum;
    logic cdone;
    logic ovld;

    int checks = 0;
    int errors = 0;

    // Reference model state: row max and sum as plain integers.
    longint m_ref = 0;
    longint l_ref = 0;
    logic signed [D_W-1:0] stim [NUM];

    online_softmax_stats #(.D_W(D_W), .FRAC(FRAC), .NUM(NUM), .SUM_W(SUM_W)) dut (
        .I_CLK(clk), .I_RST(rst), .I_VLD(vld), .O_RDY(rdy),
        .I_FIRST(first), .I_LAST(last), .I_DATA(data),
        .O_X_MAX(xmax), .O_EXP_SUM(esum), .O_CHUNK_DONE(cdone), .O_VLD(ovld)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint e2(longint d);
        longint y, n, f;
        y = -d;
        n = y / (64'd1 << FRAC);
        f = y % (64'd1 << FRAC);
        if (n > FRAC) return 0;
        return ((64'd1 << FRAC) - f / 2) >> n;
    endfunction

    function automatic longint sat(longint v);
        return (v > LSAT) ? LSAT : v;
    endfunction

    task automatic model_chunk(input bit f);
        longint mo, mx;
        mo = f ? -(64'd1 << (D_W-1)) : m_ref;
        mx = mo;
        for (int i = 0; i < NUM; i++) if (longint'(stim[i]) > mx) mx = stim[i];
        l_ref = f ? 0 : sat((l_ref * e2(mo - mx)) >> FRAC);
        m_ref = mx;
        for (int i = 0; i < NUM; i++) l_ref = sat(l_ref + e2(longint'(stim[i]) - mx));
    endtask

    task automatic scramble_bus();
        for (int i = 0; i < NUM; i++) data[i] = D_W'($urandom);
    endtask

    task automatic run_chunk(input bit f, input bit l, input string tag);
        int k;
        logic signed [D_W-1:0] exp_x;
        @(negedge clk);
        vld = 1'b1; first = f; last = l;
        for (int i = 0; i < NUM; i++) data[i] = stim[i];
        k = 0;
        while (!rdy && k < 50) begin @(negedge clk); k++; end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL %s accept timeout rdy=%0b required 1", tag, rdy);
            vld = 1'b0;
            return;
        end
        model_chunk(f);
        exp_x = m_ref[D_W-1:0];
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        scramble_bus();
        k = 1;
        while (!cdone && k < NUM + 10) begin @(negedge clk); k++; end
        checks++;
        if (k !== NUM + 3) begin errors++; $display("FAIL %s latency got %0d required %0d", tag, k, NUM + 3); end
        checks++;
        if (ovld !== l) begin errors++; $display("FAIL %s o_vld got %0b required %0b", tag, ovld, l); end
        checks++;
        if (xmax !== exp_x) begin errors++; $display("FAIL %s x_max got %h required %h", tag, xmax, exp_x); end
        checks++;
        if (esum !== SUM_W'(l_ref)) begin errors++; $display("FAIL %s exp_sum got %0d required %0d", tag, esum, l_ref); end
        @(negedge clk);
        checks++;
        if (cdone !== 1'b0 || ovld !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s pulse_end done=%0b vld=%0b rdy=%0b required 0 0 1", tag, cdone, ovld, rdy);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (xmax !== '0 || esum !== '0 || cdone !== 1'b0 || ovld !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state xmax=%h sum=%0d done=%0b vld=%0b rdy=%0b required 0 0 0 0 1", xmax, esum, cdone, ovld, rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        m_ref = 0; l_ref = 0;
    endtask

    task automatic test_vectors();
        // all zero lanes, single-chunk row
        for (int i = 0; i < NUM; i++) stim[i] = '0;
        run_chunk(1'b1, 1'b1, "zeros");
        checks++;
        if (esum !== 24'd4096 || xmax !== 16'sh0000) begin errors++; $display("FAIL zeros_const sum=%0d xmax=%h required 4096 0000", esum, xmax); end
        // one lane at +1.0
        for (int i = 0; i < NUM; i++) stim[i] = '0;
        stim[3] = 16'sh0100;
        run_chunk(1'b1, 1'b1, "lane3");
        checks++;
        if (esum !== 24'd2176 || xmax !== 16'sh0100) begin errors++; $display("FAIL lane3_const sum=%0d xmax=%h required 2176 0100", esum, xmax); end
        // two chunk row with rescale
        for (int i = 0; i < NUM; i++) stim[i] = '0;
        run_chunk(1'b1, 1'b0, "row2_a");
        checks++;
        if (esum !== 24'd4096) begin errors++; $display("FAIL row2_a_const sum=%0d required 4096", esum); end
        for (int i = 0; i < NUM; i++) stim[i] = 16'sh0100;
        run_chunk(1'b0, 1'b1, "row2_b");
        checks++;
        if (esum !== 24'd6144 || xmax !== 16'sh0100) begin errors++; $display("FAIL row2_b_const sum=%0d xmax=%h required 6144 0100", esum, xmax); end
        // fractional exponent and underflow to zero
        for (int i = 0; i < NUM; i++) stim[i] = (i < 8) ? 16'sh0000 : 16'shFF80;
        stim[15] = 16'shF000;
        run_chunk(1'b1, 1'b1, "frac");
        checks++;
        if (esum !== 24'd3392) begin errors++; $display("FAIL frac_const sum=%0d required 3392", esum); end
    endtask

    task automatic test_back_to_back();
        logic signed [D_W-1:0] sa [NUM];
        logic signed [D_W-1:0] sb [NUM];
        longint ma, la, mb, lb;
        bit exp_rdy, exp_done;
        int k;
        for (int i = 0; i < NUM; i++) begin
            sa[i] = D_W'(int'($urandom_range(0, 4095)) - 2048);
            sb[i] = D_W'(int'($urandom_range(0, 4095)) - 1024);
        end
        for (int i = 0; i < NUM; i++) stim[i] = sa[i];
        model_chunk(1'b1); ma = m_ref; la = l_ref;
        for (int i = 0; i < NUM; i++) stim[i] = sb[i];
        model_chunk(1'b0); mb = m_ref; lb = l_ref;
        @(negedge clk);
        vld = 1'b1; first = 1'b1; last = 1'b0;
        for (int i = 0; i < NUM; i++) data[i] = sa[i];
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_idle rdy=%0b required 1", rdy); end
        @(posedge clk);
        for (int kk = 1; kk <= 3 * (NUM + 4); kk++) begin
            k = kk;
            @(negedge clk);
            if (k == 1) begin
                first = 1'b0; last = 1'b1;
                for (int i = 0; i < NUM; i++) data[i] = sb[i];
            end
            if (k == NUM + 5) vld = 1'b0;
            exp_rdy  = (k == NUM + 4) || (k >= 2 * NUM + 8);
            exp_done = (k == NUM + 3) || (k == 2 * NUM + 7);
            checks++;
            if (rdy !== exp_rdy) begin errors++; $display("FAIL b2b_rdy cycle %0d got %0b required %0b", k, rdy, exp_rdy); end
            checks++;
            if (cdone !== exp_done) begin errors++; $display("FAIL b2b_done cycle %0d got %0b required %0b", k, cdone, exp_done); end
            if (k == NUM + 3) begin
                checks++;
                if (esum !== SUM_W'(la) || xmax !== D_W'(ma) || ovld !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_a sum=%0d xmax=%h vld=%0b required %0d %h 0", esum, xmax, ovld, la, D_W'(ma));
                end
            end
            if (k == 2 * NUM + 7) begin
                checks++;
                if (esum !== SUM_W'(lb) || xmax !== D_W'(mb) || ovld !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_b sum=%0d xmax=%h vld=%0b required %0d %h 1", esum, xmax, ovld, lb, D_W'(mb));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int k;
        int bad;
        for (int i = 0; i < NUM; i++) stim[i] = D_W'(int'($urandom_range(0, 2047)) - 1024);
        @(negedge clk);
        vld = 1'b1; first = 1'b1; last = 1'b1;
        for (int i = 0; i < NUM; i++) data[i] = stim[i];
        k = 0;
        while (!rdy && k < 50) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (xmax !== '0 || esum !== '0 || cdone !== 1'b0 || ovld !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset xmax=%h sum=%0d done=%0b vld=%0b rdy=%0b required 0 0 0 0 1", xmax, esum, cdone, ovld, rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        m_ref = 0; l_ref = 0;
        bad = 0;
        for (int i = 0; i < NUM + 6; i++) begin
            @(negedge clk);
            if (cdone !== 1'b0 || rdy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL post_reset_quiet bad_cycles=%0d required 0", bad); end
        for (int i = 0; i < NUM; i++) stim[i] = '0;
        run_chunk(1'b1, 1'b1, "after_reset");
        checks++;
        if (esum !== 24'd4096 || xmax !== 16'sh0000) begin errors++; $display("FAIL after_reset_const sum=%0d xmax=%h required 4096 0000", esum, xmax); end
    endtask

    task automatic test_random();
        bit row_start;
        bit f, l;
        row_start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NUM; i++) begin
                case ($urandom_range(0, 11))
                    0:       stim[i] = 16'sh8000;
                    1:       stim[i] = 16'sh7FFF;
                    2:       stim[i] = D_W'(int'($urandom_range(0, 65535)) - 32768);
                    default: stim[i] = D_W'(int'($urandom_range(0, 4095)) - 2048);
                endcase
            end
            f = row_start ? ($urandom_range(0, 4) != 0) : 1'b0;
            l = ($urandom_range(0, 2) == 0);
            run_chunk(f, l, "random");
            row_start = l;
        end
    endtask

    initial begin
        for (int i = 0; i < NUM; i++) data[i] = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
